debounce_sync: RTL and testbench
================================

// Module: debounce_sync
// PURPOSE
//   Conditions a raw asynchronous 1-bit input (switch, button, external strobe) into a clean,
//   clock-synchronous level that drives the D input of the downstream d_ff storage stage.
//   Synchronises through a flop chain, then rejects glitches shorter than DEBOUNCE_CYCLES.
//   Also emits one-cycle rise/fall pulses for the edge-triggered logic that follows.
// PARAMETERS
//   SYNC_STAGES      2  number of synchronizer flops; legal range >= 2
//   DEBOUNCE_CYCLES  4  consecutive sampled edges at the new level required to commit; >= 1
//   RESET_VAL        0  value of the sync chain, q_out and FSM home state after reset
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  derived localparam, not overridable
// PORTS
//   clock       in   1  single clock; all state updates on the rising edge
//   reset_n     in   1  asynchronous, active-low reset
//   d_in        in   1  raw asynchronous input, no timing relation to clock
//   q_out       out  1  debounced, registered level; feeds d_ff .D
//   rise_pulse  out  1  high for exactly one cycle when q_out commits 0->1
//   fall_pulse  out  1  high for exactly one cycle when q_out commits 1->0
//   busy        out  1  high while a level change is pending (FSM in a PEND state)
// BEHAVIOUR
//   Reset (reset_n low, asynchronous, takes effect immediately, including mid-count):
//     sync chain = RESET_VAL; q_out = RESET_VAL; rise_pulse = fall_pulse = busy = 0;
//     cnt = 0; state = STABLE_HI if RESET_VAL else STABLE_LO. Release: normal from next edge.
//   Sync: s = last flop of the SYNC_STAGES chain; only s enters the FSM, never d_in.
//   FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
//     STABLE_LO: s==1 -> PEND_HI, cnt=1 (if DEBOUNCE_CYCLES==1, commit directly to STABLE_HI).
//     PEND_HI:   s==0 -> STABLE_LO, cnt=0, no pulse (glitch rejected);
//                s==1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, q_out<=1, rise_pulse<=1, cnt=0;
//                else cnt<=cnt+1.
//     STABLE_HI / PEND_LO: mirror image, with fall_pulse.
//   Commit rule: s observed at the new level on DEBOUNCE_CYCLES consecutive rising edges;
//     q_out and pulse register on the last of these edges.
//   Latency: d_in captured at edge 1 -> s valid after edge SYNC_STAGES -> q_out changes at
//     edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: 6 edges). Pulse is high for the following cycle.
//   busy = 1 exactly in PEND_HI/PEND_LO; registered (state-decoded), no combinational path from d_in.
//   rise_pulse and fall_pulse are never high together; each is a registered pulse, cleared next edge.
//   Successive opposite commits are at least DEBOUNCE_CYCLES edges apart.
//   Bounce spanning a full PEND window commits; any s reversal inside the window restarts from STABLE.
//   cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
//   Input steady at q_out level: no state change, busy=0, no pulses.
// STRUCTURE
//   Shared package dbnc_pkg: FSM state encoding constants (2-bit: STABLE_LO=0, PEND_HI=1,
//     STABLE_HI=2, PEND_LO=3) and clog2 helper for CNT_W.
//   Sub-module sync_chain #(N): N-flop 1-bit synchronizer, async active-low reset to RESET_VAL.
//   Top level: sync_chain instance + FSM/counter + output registers.
// TESTING
//   T1 reset: assert reset_n=0 mid-PEND_HI (cnt=2) -> q_out=0, busy=0, pulses 0 immediately, no rise.
//   T2 clean rise: d_in 0->1 held 10 cycles -> q_out=1 at edge 6 (defaults), rise_pulse high for 1 cycle.
//   T3 glitch: d_in high for 2 cycles then low -> q_out stays 0, busy high 2 cycles, no pulse.
//   T4 bounce: d_in toggles 1,0,1,0 each cycle then held 1 -> single rise_pulse, 6 edges after last toggle.
//   T5 fall: from q_out=1, d_in 1->0 held -> fall_pulse once, q_out=0; rise_pulse stays 0 throughout.
//   T6 params: SYNC_STAGES=3, DEBOUNCE_CYCLES=1 -> q_out follows d_in 4 edges later, pulse every change.

Source files
------------

// File: rtl/dbnc_pkg.sv
// Shared definitions for the debounce/synchronizer block: FSM state encoding
// and the counter-width helper.
package dbnc_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } dbnc_state_e;

   // Bits needed to hold values 0..value-1; never less than one bit.
   function automatic int clog2_f(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// N-flop single-bit synchronizer; every flop resets asynchronously to RESET_VAL.
module sync_chain #(
   parameter int   N         = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] sync_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {N{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[N-2:0], d_i};
      end
   end

   assign q_o = sync_q[N-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous input, then commits a new level only after it
// has been seen DEBOUNCE_CYCLES consecutive edges; emits one-cycle edge pulses.
//
// state     | meaning
// STABLE_LO | q_out = 0, synchronized input agrees
// PEND_HI   | input seen high, counting towards a rise commit
// STABLE_HI | q_out = 1, synchronized input agrees
// PEND_LO   | input seen low, counting towards a fall commit
module debounce_sync
   import dbnc_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d_in,
   output logic q_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   localparam int                CNT_W    = clog2_f(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam dbnc_state_e       HOME     = RESET_VAL ? STABLE_HI : STABLE_LO;

   logic             s;
   dbnc_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_out_q, q_out_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   sync_chain #(
      .N         (SYNC_STAGES),
      .RESET_VAL (RESET_VAL)
   ) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     (d_in),
      .q_o     (s)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= HOME;
         cnt_q   <= '0;
         q_out_q <= RESET_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_out_q <= q_out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // The edge that leaves a STABLE state already counts as the first sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_out_d = q_out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         STABLE_LO: begin
            if (s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = STABLE_HI;
                  q_out_d = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  state_d = PEND_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         PEND_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               q_out_d = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STABLE_HI: begin
            if (!s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = STABLE_LO;
                  q_out_d = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = PEND_LO;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         PEND_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               q_out_d = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = HOME;
            cnt_d   = '0;
         end
      endcase
   end

   assign q_out      = q_out_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = (state_q == PEND_HI) || (state_q == PEND_LO);

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance plus a 3-stage / 1-cycle instance,
// checked every cycle against a run-length model, plus hand-computed pins.
module tb_debounce_sync;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic d_in = 1'b0;

   logic q_a, rise_a, fall_a, busy_a;
   logic q_b, rise_b, fall_b, busy_b;

   int checks = 0;
   int failures = 0;

   debounce_sync dut_a (
      .clock      (clock),
      .reset_n    (reset_n),
      .d_in       (d_in),
      .q_out      (q_a),
      .rise_pulse (rise_a),
      .fall_pulse (fall_a),
      .busy       (busy_a)
   );

   debounce_sync #(
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (1),
      .RESET_VAL       (1'b0)
   ) dut_b (
      .clock      (clock),
      .reset_n    (reset_n),
      .d_in       (d_in),
      .q_out      (q_b),
      .rise_pulse (rise_b),
      .fall_pulse (fall_b),
      .busy       (busy_b)
   );

   always #5 clock = ~clock;

   // Model: the value the debouncer sees at edge k is d_in sampled N edges
   // earlier; q flips once D consecutive seen values disagree with it.
   int nst [2] = '{2, 3};
   int dcy [2] = '{4, 1};
   bit dh [$];
   bit mq [2];
   bit mrise [2];
   bit mfall [2];
   bit mbusy [2];
   int run [2];
   int rise_cnt [2];
   int fall_cnt [2];
   bit ms;

   initial begin
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) begin
            dh.delete();
            for (int i = 0; i < 2; i++) begin
               mq[i] = 1'b0; mrise[i] = 1'b0; mfall[i] = 1'b0;
               mbusy[i] = 1'b0; run[i] = 0;
            end
         end else begin
            for (int i = 0; i < 2; i++) begin
               ms = (dh.size() >= nst[i]) ? dh[dh.size() - nst[i]] : 1'b0;
               mrise[i] = 1'b0;
               mfall[i] = 1'b0;
               if (ms == mq[i]) run[i] = 0;
               else run[i] = run[i] + 1;
               if (run[i] >= dcy[i]) begin
                  mq[i] = ms;
                  mrise[i] = ms;
                  mfall[i] = !ms;
                  run[i] = 0;
               end
               mbusy[i] = (ms != mq[i]);
            end
            dh.push_back(d_in);
         end
      end
   end

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0b exp=%0b at t=%0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [3:0] da, db;
      forever begin
         @(negedge clock);
         da = {q_a, rise_a, fall_a, busy_a};
         db = {q_b, rise_b, fall_b, busy_b};
         check1("a_q",    da[3], mq[0]);
         check1("a_rise", da[2], mrise[0]);
         check1("a_fall", da[1], mfall[0]);
         check1("a_busy", da[0], mbusy[0]);
         check1("b_q",    db[3], mq[1]);
         check1("b_rise", db[2], mrise[1]);
         check1("b_fall", db[1], mfall[1]);
         check1("b_busy", db[0], mbusy[1]);
         check1("a_pulse_excl", rise_a & fall_a, 1'b0);
         if (rise_a) rise_cnt[0]++;
         if (fall_a) fall_cnt[0]++;
         if (rise_b) rise_cnt[1]++;
         if (fall_b) fall_cnt[1]++;
      end
   end

   task automatic edges(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check_cnt(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   initial begin
      int r0, f0;
      edges(3);
      reset_n = 1'b1;
      edges(4);

      // T1: reset while counting towards a rise
      d_in = 1'b1;
      edges(4);
      check1("t1_busy_before", busy_a, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check1("t1_q_a",    q_a, 1'b0);
      check1("t1_busy_a", busy_a, 1'b0);
      check1("t1_rise_a", rise_a, 1'b0);
      check1("t1_q_b",    q_b, 1'b0);
      d_in = 1'b0;
      edges(3);
      reset_n = 1'b1;
      edges(4);
      check_cnt("t1_no_rise", rise_cnt[0], 0);

      // T2: clean rise
      d_in = 1'b1;
      edges(2);
      check1("t2_busy_e2", busy_a, 1'b0);
      edges(1);
      check1("t2_busy_e3", busy_a, 1'b1);
      check1("t2_b_q_e3",  q_b, 1'b0);
      edges(1);
      check1("t2_b_q_e4",    q_b, 1'b1);
      check1("t2_b_rise_e4", rise_b, 1'b1);
      edges(1);
      check1("t2_q_e5", q_a, 1'b0);
      edges(1);
      check1("t2_q_e6",    q_a, 1'b1);
      check1("t2_rise_e6", rise_a, 1'b1);
      edges(1);
      check1("t2_rise_e7", rise_a, 1'b0);
      check1("t2_q_e7",    q_a, 1'b1);
      edges(3);

      // return to low for glitch test
      d_in = 1'b0;
      edges(10);
      check1("t2_back_low", q_a, 1'b0);

      // T3: two-cycle glitch
      r0 = rise_cnt[0];
      d_in = 1'b1;
      edges(2);
      d_in = 1'b0;
      check1("t3_busy_e2", busy_a, 1'b0);
      edges(1);
      check1("t3_busy_e3", busy_a, 1'b1);
      edges(1);
      check1("t3_busy_e4", busy_a, 1'b1);
      edges(1);
      check1("t3_busy_e5", busy_a, 1'b0);
      edges(5);
      check1("t3_q", q_a, 1'b0);
      check_cnt("t3_no_rise", rise_cnt[0], r0);

      // T4: bounce 1,0,1,0 then held high
      r0 = rise_cnt[0];
      for (int i = 0; i < 4; i++) begin
         d_in = (i % 2 == 0);
         edges(1);
      end
      d_in = 1'b1;
      edges(5);
      check1("t4_q_e5", q_a, 1'b0);
      edges(1);
      check1("t4_q_e6",    q_a, 1'b1);
      check1("t4_rise_e6", rise_a, 1'b1);
      edges(6);
      check_cnt("t4_one_rise", rise_cnt[0] - r0, 1);

      // T5: fall from high
      r0 = rise_cnt[0];
      f0 = fall_cnt[0];
      d_in = 1'b0;
      edges(5);
      check1("t5_q_e5", q_a, 1'b1);
      edges(1);
      check1("t5_q_e6",    q_a, 1'b0);
      check1("t5_fall_e6", fall_a, 1'b1);
      edges(6);
      check_cnt("t5_one_fall", fall_cnt[0] - f0, 1);
      check_cnt("t5_no_rise",  rise_cnt[0], r0);

      // randomized hold lengths with occasional asynchronous reset
      for (int i = 0; i < 400; i++) begin
         d_in = 1'($urandom_range(0, 1));
         edges($urandom_range(1, 9));
         if ($urandom_range(0, 39) == 0) begin
            #3 reset_n = 1'b0;
            edges($urandom_range(1, 3));
            reset_n = 1'b1;
         end
      end
      edges(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
